// File: rtl/apb_regs_wrapper_if.sv
// Host-side transaction port of apb_regs_wrapper: request/response strobes,
// level interrupt out and the three done status inputs.
interface apb_regs_wrapper_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  tx_valid;
  logic [1:0]            tx_encode;
  logic [ADDR_WIDTH-1:0] tx_addr;
  logic [DATA_WIDTH-1:0] tx_wdata;
  logic [DATA_WIDTH-1:0] tx_rdata;
  logic                  tx_rvalid;
  logic                  Intr;
  logic                  Tx_done_i;
  logic                  Rx_done_i;
  logic                  Arb_done_i;

  modport master (
    output tx_valid, tx_encode, tx_addr, tx_wdata, Tx_done_i, Rx_done_i, Arb_done_i,
    input  tx_rdata, tx_rvalid, Intr
  );

  modport slave (
    input  tx_valid, tx_encode, tx_addr, tx_wdata, Tx_done_i, Rx_done_i, Arb_done_i,
    output tx_rdata, tx_rvalid, Intr
  );
endinterface

// File: rtl/apb_regs_wrapper.sv
// Transaction port -> internal APB3 master -> 11-word register file (0x00-0x28).
// Optional macro APB_SLVERR_EN: slave error response plus sticky error bit INTR_STAT[3].
module apb_regs_wrapper #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic               pclk,
  input logic               preset,
  apb_regs_wrapper_if.slave bus
);
`ifdef APB_SLVERR_EN
  localparam int IW = 4;
`else
  localparam int IW = 3;
`endif
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata, prdata;
  logic                  pwrite, psel, penable, pready, pslverr;
  logic                  req, cap, acc, hit, wr;
  logic [3:0]            idx;

  logic [DATA_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0] data [7];
  logic [2:0]            status;
  logic [IW-1:0]         intr_en, intr_stat, stat_set, stat_clr;
  logic                  intr, rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  assign req     = bus.tx_valid & ~bus.tx_encode[1];
  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);
  assign pready  = 1'b1;
  assign acc     = psel & penable;
  // a new request is only taken in IDLE or in the completing ACCESS cycle
  assign cap     = req & ((state == IDLE) | (acc & pready));

  always_ff @(posedge pclk or posedge preset)
    if (preset) state <= IDLE;
    else
      case (state)
        IDLE:    if (cap) state <= SETUP;
        SETUP:   state <= ACCESS;
        ACCESS:  if (pready) state <= cap ? SETUP : IDLE;
        default: state <= IDLE;
      endcase

  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else if (cap) begin
      paddr  <= bus.tx_addr;
      pwdata <= bus.tx_wdata;
      pwrite <= bus.tx_encode[0];
    end

  assign idx = paddr[5:2];
  assign hit = (paddr[1:0] == 2'b00) & ~|paddr[ADDR_WIDTH-1:6] & (idx <= 4'd10);
  assign wr  = acc & pready & pwrite & hit & (idx != 4'd1);

  always_comb begin
    prdata = '0;
    if (hit)
      case (idx)
        4'd0:    prdata = ctrl;
        4'd1:    prdata = DATA_WIDTH'(status);
        4'd2:    prdata = DATA_WIDTH'(intr_en);
        4'd3:    prdata = DATA_WIDTH'(intr_stat);
        default: prdata = data[3'(idx - 4'd4)];
      endcase
  end

`ifdef APB_SLVERR_EN
  assign pslverr  = acc & (~hit | (pwrite & (idx == 4'd1)));
  assign stat_set = {pslverr & pready, bus.Arb_done_i, bus.Rx_done_i, bus.Tx_done_i};
`else
  assign pslverr  = 1'b0;
  assign stat_set = {bus.Arb_done_i, bus.Rx_done_i, bus.Tx_done_i};
`endif
  assign stat_clr = (wr && idx == 4'd3) ? pwdata[IW-1:0] : '0;

  // set is OR-ed after the clear so a new event wins over a simultaneous W1C
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      ctrl      <= '0;
      status    <= '0;
      intr_en   <= '0;
      intr_stat <= '0;
      intr      <= 1'b0;
      for (int i = 0; i < 7; i++) data[i] <= '0;
    end else begin
      status    <= {bus.Arb_done_i, bus.Rx_done_i, bus.Tx_done_i};
      intr_stat <= (intr_stat & ~stat_clr) | stat_set;
      intr      <= |(intr_stat & intr_en);
      if (wr)
        case (idx)
          4'd0:       ctrl <= pwdata;
          4'd2:       intr_en <= pwdata[IW-1:0];
          4'd1, 4'd3: ;
          default:    data[3'(idx - 4'd4)] <= pwdata;
        endcase
    end

  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= acc & pready & ~pwrite;
      if (acc & pready & ~pwrite) rdata <= pslverr ? '0 : prdata;
    end

  assign bus.tx_rvalid = rvalid;
  assign bus.tx_rdata  = rdata;
  assign bus.Intr      = intr;
endmodule

// File: tb/tb_apb_regs_wrapper.sv
// Directed plus random requests against a word-level model of the register map;
// every read response and the interrupt level are compared with the model.
module tb_apb_regs_wrapper;
  logic pclk = 1'b0;
  logic preset = 1'b1;

  apb_regs_wrapper_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus();
  apb_regs_wrapper #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .pclk(pclk), .preset(preset), .bus(bus)
  );

  always #5 pclk = ~pclk;

`ifdef APB_SLVERR_EN
  localparam bit          ERR_EN = 1'b1;
  localparam logic [31:0] IMASK  = 32'hF;
`else
  localparam bit          ERR_EN = 1'b0;
  localparam logic [31:0] IMASK  = 32'h7;
`endif

  int          total = 0, bad = 0;
  logic [31:0] rq[$], eq[$];
  logic [31:0] m_reg [11];
  logic [31:0] m_en, m_stat;
  logic [2:0]  m_dn;

  always @(negedge pclk) if (bus.tx_rvalid) rq.push_back(bus.tx_rdata);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mapped(input logic [15:0] a);
    return (a[1:0] == 2'b00) && (a <= 16'h28);
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    if (!mapped(a)) return 32'h0;
    case (a >> 2)
      1:       return {29'b0, m_dn};
      2:       return m_en;
      3:       return m_stat;
      default: return m_reg[a >> 2];
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 11; i++) m_reg[i] = 32'h0;
    m_en = 32'h0;
    m_stat = 32'h0;
  endtask

  task automatic m_req(input logic [1:0] enc, input logic [15:0] a, input logic [31:0] d);
    if (enc[1]) return;
    if (!mapped(a) || (enc[0] && a == 16'h4)) begin
      if (ERR_EN) m_stat[3] = 1'b1;
    end
    if (!enc[0]) eq.push_back(m_read(a));
    else if (mapped(a))
      case (a >> 2)
        1: ;
        2: m_en = d & IMASK;
        3: m_stat = (m_stat & ~(d & IMASK)) | {29'b0, m_dn};
        default: m_reg[a >> 2] = d;
      endcase
  endtask

  task automatic set_dn(input logic [2:0] v);
    {bus.Arb_done_i, bus.Rx_done_i, bus.Tx_done_i} = v;
    m_dn = v;
    m_stat = m_stat | {29'b0, v};
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic drive(input logic [1:0] enc, input logic [15:0] a, input logic [31:0] d);
    bus.tx_valid = 1'b1;
    bus.tx_encode = enc;
    bus.tx_addr = a;
    bus.tx_wdata = d;
  endtask

  task automatic send(input logic [1:0] enc, input logic [15:0] a, input logic [31:0] d);
    @(negedge pclk);
    drive(enc, a, d);
    m_req(enc, a, d);
    @(negedge pclk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    chk({tag, "_cnt"}, rq.size(), eq.size());
    while (rq.size() > 0 && eq.size() > 0) chk(tag, rq.pop_front(), eq.pop_front());
    rq.delete();
    eq.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [1:0]  enc;
    logic [31:0] d;
    int          w, e;

    bus.tx_valid = 1'b0; bus.tx_encode = 2'b00; bus.tx_addr = '0; bus.tx_wdata = '0;
    m_reset();
    set_dn(3'b000);
    settle(3);
    chk("rst_rvalid", bus.tx_rvalid, 0);
    chk("rst_intr", bus.Intr, 0);
    chk("rst_rdata", bus.tx_rdata, 0);
    preset = 1'b0;
    settle(2);

    // full-map sweep at the minimum request spacing
    for (int i = 0; i < 11; i++) send(2'b01, 16'(i * 4), 32'hA500_0000 | 32'(i * 32'h1111));
    for (int i = 0; i < 11; i++) send(2'b00, 16'(i * 4), 32'h0);
    settle(4);
    drain("sweep");

    set_dn(3'b101);
    send(2'b00, 16'h4, 32'h0);
    send(2'b01, 16'h4, 32'hFFFF_FFFF);
    send(2'b00, 16'h4, 32'h0);
    settle(4);
    drain("status");

    set_dn(3'b111);
    send(2'b01, 16'h8, 32'h7);
    settle(3);
    chk("intr_on", bus.Intr, 1);
    set_dn(3'b000);
    send(2'b01, 16'hC, 32'h7);
    settle(2);
    chk("intr_hold", bus.Intr, 1);
    settle(1);
    chk("intr_off", bus.Intr, 0);

    // second request one cycle after the first lands in SETUP and is dropped
    send(2'b01, 16'h14, 32'h0);
    settle(2);
    @(negedge pclk); drive(2'b01, 16'h10, 32'h1234_5678); m_req(2'b01, 16'h10, 32'h1234_5678);
    @(negedge pclk); drive(2'b01, 16'h14, 32'hBBBB_BBBB);
    @(negedge pclk); bus.tx_valid = 1'b0;
    send(2'b11, 16'h18, 32'hDEAD_BEEF);
    send(2'b10, 16'h1C, 32'hCAFE_F00D);
    for (int i = 4; i < 8; i++) send(2'b00, 16'(i * 4), 32'h0);
    settle(4);
    drain("b2b");

    send(2'b01, 16'h8, 32'hF);
    send(2'b00, 16'h40, 32'h0);
    settle(4);
    drain("unmap");
    chk("unmap_intr", bus.Intr, |(m_stat & m_en));

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 4) == 0) set_dn(3'($urandom_range(0, 7)));
      w = $urandom_range(0, 15);
      if (w < 11)       a = 16'(w * 4);
      else if (w == 11) a = 16'h40;
      else if (w == 12) a = 16'h2C;
      else if (w == 13) a = 16'($urandom_range(0, 10) * 4 + $urandom_range(1, 3));
      else if (w == 14) a = 16'hC;
      else              a = 16'h8;
      e = $urandom_range(0, 9);
      enc = (e < 4) ? 2'b00 : (e < 8) ? 2'b01 : (e == 8) ? 2'b10 : 2'b11;
      d = $urandom();
      send(enc, a, d);
      settle(4);
      drain("rnd");
      chk("rnd_intr", bus.Intr, |(m_stat & m_en));
    end

    // reset in the ACCESS cycle of a read, with the interrupt raised beforehand
    set_dn(3'b111);
    send(2'b01, 16'h8, 32'h7);
    settle(3);
    eq.delete(); rq.delete();
    send(2'b00, 16'h10, 32'h0);
    @(negedge pclk);
    preset = 1'b1;
    #1;
    chk("mid_rst_rvalid", bus.tx_rvalid, 0);
    chk("mid_rst_intr", bus.Intr, 0);
    eq.delete();
    m_reset();
    set_dn(3'b101);
    settle(2);
    preset = 1'b0;
    settle(2);
    chk("rst_abort", rq.size(), 0);
    for (int i = 0; i < 11; i++) send(2'b00, 16'(i * 4), 32'h0);
    settle(4);
    drain("post_rst");
    chk("post_rst_intr", bus.Intr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
